decode_stage: RTL and testbench

Instruction decode stage of the H2BP core, between fetch and execute. It accepts one RV32I instruction per cycle over a valid/ready handshake and drives the register file read ports (enables and addresses) in the accept cycle. It registers the decoded fields so they appear to execute together with the register file's registered operands. It also detects load-use hazards and stalls fetch until the load result can be forwarded.

---
 rtl/decode_stage.sv | 178 +++++++++++++++++
 tb/tb_decode_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file read port drive, registered decode bundle toward execute.
// Optional load-use stall (hazard logic and pending-load tracking) enabled by H2BP_LOAD_USE_STALL_EN.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    output logic        decode_ready,
    output logic        operand_a_enable,
    output logic        operand_b_enable,
    output logic [4:0]  operand_a_addr,
    output logic [4:0]  operand_b_addr,
    output logic        dec_valid,
    input  logic        exec_ready,
    output logic [6:0]  dec_opcode,
    output logic [2:0]  dec_funct3,
    output logic        dec_funct7_5,
    output logic [4:0]  dec_rd,
    output logic [31:0] dec_imm,
    output logic        dec_use_imm,
    output logic [31:0] dec_pc,
    output logic        dec_illegal,
    input  logic        load_done
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILLEGAL
    } fmt_e;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    fmt_e        fmt;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_written;
    logic        use_imm;
    logic [31:0] imm;
    logic        hazard;
    logic        accept;

    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fmt = FMT_ILLEGAL;
        unique case (opcode)
            OPC_OP:                                   fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM:                    fmt = FMT_I;
            OPC_STORE:                                fmt = FMT_S;
            OPC_BRANCH:                               fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                       fmt = FMT_U;
            OPC_JAL:                                  fmt = FMT_J;
            default:                                  fmt = FMT_ILLEGAL;
        endcase
    end

    always_comb begin
        imm = 32'd0;
        unique case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'd0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    assign rs1_used   = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign rs2_used   = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign rd_written = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
    assign use_imm    = (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_U) || (fmt == FMT_J);

`ifdef H2BP_LOAD_USE_STALL_EN
    logic       pend_valid;
    logic [4:0] pend_rd;
    logic       pend_live;
    logic       held_load;
    logic       load_handoff;
    logic       hit_held;
    logic       hit_pend;

    // A pending load stops blocking in its load_done cycle: the bypass covers that edge.
    assign pend_live    = pend_valid && !load_done;
    assign held_load    = dec_valid && (dec_opcode == OPC_LOAD) && (dec_rd != 5'd0);
    assign load_handoff = held_load && exec_ready;

    assign hit_held = held_load &&
                      ((rs1_used && (rs1 != 5'd0) && (rs1 == dec_rd)) ||
                       (rs2_used && (rs2 != 5'd0) && (rs2 == dec_rd)));
    assign hit_pend = pend_live &&
                      ((rs1_used && (rs1 != 5'd0) && (rs1 == pend_rd)) ||
                       (rs2_used && (rs2 != 5'd0) && (rs2 == pend_rd)));

    assign hazard = instr_valid &&
                    (hit_held || hit_pend || (pend_live && (opcode == OPC_LOAD)));

    // A new handoff wins over load_done, which always refers to the older load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_rd    <= 5'd0;
        end else if (load_handoff) begin
            pend_valid <= 1'b1;
            pend_rd    <= dec_rd;
        end else if (load_done) begin
            pend_valid <= 1'b0;
        end
    end
`else
    logic unused_load_done;

    assign unused_load_done = load_done;
    assign hazard           = 1'b0;
`endif

    // Held low through reset so fetch cannot hand over an instruction that would be dropped.
    assign decode_ready = rst_n && (!dec_valid || exec_ready) && !hazard;
    assign accept       = instr_valid && decode_ready;

    assign operand_a_enable = accept && rs1_used;
    assign operand_b_enable = accept && rs2_used;
    assign operand_a_addr   = rs1;
    assign operand_b_addr   = rs2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid    <= 1'b0;
            dec_opcode   <= 7'd0;
            dec_funct3   <= 3'd0;
            dec_funct7_5 <= 1'b0;
            dec_rd       <= 5'd0;
            dec_imm      <= 32'd0;
            dec_use_imm  <= 1'b0;
            dec_pc       <= 32'd0;
            dec_illegal  <= 1'b0;
        end else if (accept) begin
            dec_valid    <= 1'b1;
            dec_opcode   <= opcode;
            dec_funct3   <= instr[14:12];
            dec_funct7_5 <= instr[30];
            dec_rd       <= rd_written ? rd : 5'd0;
            dec_imm      <= imm;
            dec_use_imm  <= use_imm;
            dec_pc       <= instr_pc;
            dec_illegal  <= (fmt == FMT_ILLEGAL);
        end else if (exec_ready) begin
            dec_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow H2BP_LOAD_USE_STALL_EN when defined.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;
    logic        operand_a_enable;
    logic        operand_b_enable;
    logic [4:0]  operand_a_addr;
    logic [4:0]  operand_b_addr;
    logic        dec_valid;
    logic        exec_ready;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic        dec_funct7_5;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic [31:0] dec_pc;
    logic        dec_illegal;
    logic        load_done;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .decode_ready     (decode_ready),
        .operand_a_enable (operand_a_enable),
        .operand_b_enable (operand_b_enable),
        .operand_a_addr   (operand_a_addr),
        .operand_b_addr   (operand_b_addr),
        .dec_valid        (dec_valid),
        .exec_ready       (exec_ready),
        .dec_opcode       (dec_opcode),
        .dec_funct3       (dec_funct3),
        .dec_funct7_5     (dec_funct7_5),
        .dec_rd           (dec_rd),
        .dec_imm          (dec_imm),
        .dec_use_imm      (dec_use_imm),
        .dec_pc           (dec_pc),
        .dec_illegal      (dec_illegal),
        .load_done        (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        instr_pc    = 32'd0;
        exec_ready  = 1'b0;
        load_done   = 1'b0;

        tick();
        check("rst_ready", decode_ready, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_imm", dec_imm, 0);
        check("rst_pc", dec_pc, 0);
        tick();
        #2 rst_n = 1'b1;

        // addi x1,x2,5
        instr_valid = 1'b1;
        exec_ready  = 1'b1;
        instr       = 32'h00510093;
        instr_pc    = 32'h0000_0100;
        #1;
        check("addi_ready", decode_ready, 1);
        check("addi_a_en", operand_a_enable, 1);
        check("addi_a_addr", operand_a_addr, 2);
        check("addi_b_en", operand_b_enable, 0);
        tick();
        check("addi_valid", dec_valid, 1);
        check("addi_rd", dec_rd, 1);
        check("addi_imm", dec_imm, 32'h0000_0005);
        check("addi_use_imm", dec_use_imm, 1);
        check("addi_opcode", dec_opcode, 7'h13);
        check("addi_pc", dec_pc, 32'h0000_0100);
        check("addi_illegal", dec_illegal, 0);

        // sw x2,-4(x1)
        instr    = 32'hFE20AE23;
        instr_pc = 32'h0000_0104;
        #1;
        check("sw_a_en", operand_a_enable, 1);
        check("sw_b_en", operand_b_enable, 1);
        check("sw_a_addr", operand_a_addr, 1);
        check("sw_b_addr", operand_b_addr, 2);
        tick();
        check("sw_imm", dec_imm, 32'hFFFF_FFFC);
        check("sw_rd", dec_rd, 0);
        check("sw_funct3", dec_funct3, 2);
        check("sw_use_imm", dec_use_imm, 1);

        // beq x1,x2,-4
        instr    = 32'hFE208EE3;
        instr_pc = 32'h0000_0108;
        #1;
        check("beq_b_en", operand_b_enable, 1);
        tick();
        check("beq_imm", dec_imm, 32'hFFFF_FFFC);
        check("beq_rd", dec_rd, 0);
        check("beq_use_imm", dec_use_imm, 0);
        check("beq_f7_5", dec_funct7_5, 1);

        // jal x1,8
        instr    = 32'h008000EF;
        instr_pc = 32'h0000_010C;
        #1;
        check("jal_a_en", operand_a_enable, 0);
        check("jal_b_en", operand_b_enable, 0);
        tick();
        check("jal_imm", dec_imm, 32'h0000_0008);
        check("jal_rd", dec_rd, 1);

        // lw x3,0(x1) followed by add x4,x3,x5
        instr    = 32'h0000A183;
        instr_pc = 32'h0000_0110;
        #1;
        check("lw_ready", decode_ready, 1);
        tick();
        check("lw_rd", dec_rd, 3);
        check("lw_use_imm", dec_use_imm, 1);
        instr    = 32'h00518233;
        instr_pc = 32'h0000_0114;
        #1;
`ifdef H2BP_LOAD_USE_STALL_EN
        check("lu_held_ready", decode_ready, 0);
        check("lu_held_a_en", operand_a_enable, 0);
        tick();
        check("lu_handoff_valid", dec_valid, 0);
        check("lu_pend_ready", decode_ready, 0);
        tick();
        check("lu_pend_ready2", decode_ready, 0);
        load_done = 1'b1;
        #1;
        check("lu_done_ready", decode_ready, 1);
        check("lu_done_a_en", operand_a_enable, 1);
        check("lu_done_a_addr", operand_a_addr, 3);
        check("lu_done_b_en", operand_b_enable, 1);
        tick();
        load_done = 1'b0;
`else
        check("nostall_ready", decode_ready, 1);
        check("nostall_a_en", operand_a_enable, 1);
        check("nostall_a_addr", operand_a_addr, 3);
        tick();
`endif
        check("add_valid", dec_valid, 1);
        check("add_rd", dec_rd, 4);
        check("add_use_imm", dec_use_imm, 0);
        check("add_imm", dec_imm, 0);
        check("add_pc", dec_pc, 32'h0000_0114);

        // Backpressure: addi held for three cycles while lui waits
        instr    = 32'h00510093;
        instr_pc = 32'h0000_0200;
        tick();
        exec_ready = 1'b0;
        instr      = 32'h123452B7;
        instr_pc   = 32'h0000_0204;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", decode_ready, 0);
            check("bp_rd", dec_rd, 1);
            check("bp_imm", dec_imm, 32'h0000_0005);
            check("bp_pc", dec_pc, 32'h0000_0200);
            check("bp_valid", dec_valid, 1);
            tick();
        end
        exec_ready = 1'b1;
        #1;
        check("bp_release_ready", decode_ready, 1);
        tick();
        check("lui_rd", dec_rd, 5);
        check("lui_imm", dec_imm, 32'h1234_5000);
        check("lui_opcode", dec_opcode, 7'h37);
        check("lui_pc", dec_pc, 32'h0000_0204);

        // Illegal opcode
        instr    = 32'h0000007F;
        instr_pc = 32'h0000_0208;
        #1;
        check("ill_ready", decode_ready, 1);
        check("ill_a_en", operand_a_enable, 0);
        check("ill_b_en", operand_b_enable, 0);
        tick();
        check("ill_valid", dec_valid, 1);
        check("ill_flag", dec_illegal, 1);
        check("ill_rd", dec_rd, 0);

        // Reset while stalled
        instr    = 32'h0000A183;
        instr_pc = 32'h0000_0300;
        tick();
        instr    = 32'h00518233;
        instr_pc = 32'h0000_0304;
`ifdef H2BP_LOAD_USE_STALL_EN
        tick();
        check("rs_stalled", decode_ready, 0);
`else
        exec_ready = 1'b0;
        #1;
        check("rs_stalled", decode_ready, 0);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rs_valid", dec_valid, 0);
        check("rs_ready", decode_ready, 0);
        #1 rst_n = 1'b1;
        exec_ready = 1'b1;
        #1;
        check("rs_replay_ready", decode_ready, 1);
        check("rs_replay_a_en", operand_a_enable, 1);
        tick();
        check("rs_replay_rd", dec_rd, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
